mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk_in  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_in  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rdy_in  in  1  global ready; low = freeze.
REQ-004 SHALL have ports: clear  in  1  pipeline flush (branch mispredict).
REQ-005 SHALL have ports: mem_din  in  8  RAM read byte; mem_dout  out  8  RAM write byte; mem_a  out  32  RAM byte address; mem_wr  out  1  RAM write strobe (1 = write).
REQ-006 SHALL have ports: io_buffer_full  in  1  UART buffer full.
REQ-007 SHALL have ports: if_req  in  1; if_addr  in  32; if_done  out  1; if_data  out  32. Instruction-fetch channel, always 4-byte read.
REQ-008 SHALL have ports: ls_req  in  1; ls_we  in  1; ls_op  in  3 (RV funct3); ls_addr  in  32; ls_wdata  in  32; ls_done  out  1; ls_rdata  out  32. Load/store channel.

Function
REQ-009 SHALL implement FSM states IDLE, IF_RD, LS_RD, LS_WR, plus a 3-bit byte counter cnt and a 1-bit last_served flag.
REQ-010 SHALL treat RAM as 1-cycle latency: the byte for the address driven in cycle k appears on mem_din in cycle k+1.
REQ-011 SHALL set access length N from ls_op[1:0]: 00=1, 01=2, 10=4 bytes; IF N=4; bytes little-endian at addr..addr+N-1.
REQ-012 In IDLE with exactly one req high in cycle t, SHALL grant that requester; the first byte address SHALL appear on mem_a in cycle t+1.
REQ-013 In IDLE with both reqs high, SHALL grant the requester not equal to last_served; last_served SHALL update on each grant.
REQ-014 Read: SHALL drive addresses in cycles t+1..t+N with mem_wr=0, assemble bytes, and pulse done for exactly one cycle in t+N+2, with data valid in that cycle.
REQ-015 Write: SHALL drive mem_wr=1, mem_a=addr+i, mem_dout=ls_wdata[8i+7:8i] in cycles t+1..t+N, and pulse ls_done in cycle t+N+1.
REQ-016 Load result SHALL be sign-extended when ls_op[2]=0 and zero-extended when ls_op[2]=1 for N<4.
REQ-017 if_addr, ls_addr, ls_op, ls_we, and ls_wdata SHALL be latched at grant; requesters hold req until done; req changes during an access SHALL be ignored.
REQ-018 In the cycle done is asserted, the FSM SHALL be IDLE and SHALL NOT grant the requester whose done is high; the other requester may be granted.
REQ-019 For a write with ls_addr[17:16]==2'b11 (IO space) while io_buffer_full=1, SHALL hold the current byte (mem_wr=0, cnt frozen) until io_buffer_full=0.
REQ-020 clear=1 SHALL abort IF_RD and LS_RD to IDLE on the next edge with no done pulse; LS_WR SHALL NOT be aborted (committed store) and SHALL complete normally.
REQ-021 clear=1 in IDLE SHALL suppress grants in that cycle.
REQ-022 rdy_in=0 SHALL freeze all state, counters, and outputs, except mem_wr, which SHALL be forced to 0; the access SHALL resume unchanged when rdy_in=1.
REQ-023 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
REQ-024 mem_a/mem_dout SHALL be 0 and mem_wr SHALL be 0 in IDLE.

Reset
REQ-025 rst_in=1 SHALL force IDLE, cnt=0, last_served=LS (so IF wins the first tie), mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, immediately and asynchronously.
REQ-026 Reset mid-access SHALL abandon the access with no done pulse; the requester must re-request.

Verification
REQ-027 if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 in t+1..t+4; if_done pulse at t+6 with if_data=0x00000513.
REQ-028 ls_req, ls_we=0, ls_op=000 (lb), addr=0x20, RAM[0x20]=0x80 -> ls_done at t+3, ls_rdata=0xFFFFFF80; repeat with ls_op=100 (lbu) -> 0x00000080.
REQ-029 ls_we=1, ls_op=001 (sh), addr=0x40, wdata=0x1234ABCD -> mem_wr=1 at 0x40/0xCD then 0x41/0xAB; ls_done at t+3; RAM[0x42] unchanged.
REQ-030 if_req and ls_req both high from reset -> IF served first, then LS granted in IF's done cycle; a subsequent tie goes to IF again.
REQ-031 clear during IF_RD cnt=2 -> IDLE next cycle with no if_done; clear during sw -> all 4 bytes written, ls_done pulses.
REQ-032 sb to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 during those cycles, then the byte is written and ls_done fires; rdy_in=0 mid-read -> mem_wr=0 and the result is still correct.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and load/store.
// Assembles multi-byte reads and splits writes over a 1-cycle-latency byte RAM.
//
// state | meaning
// IDLE  | no access in flight; arbitrates between if_req and ls_req
// IF_RD | 4-byte instruction fetch, one address per cycle then one tail cycle
// LS_RD | 1/2/4-byte load, same timing as IF_RD, result extended on completion
// LS_WR | 1/2/4-byte store, one byte per cycle, may stall on a full UART buffer
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        last_q, last_d;   // 1 = load/store was granted most recently
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        rdy_prev_q, rdy_prev_d;
  logic [7:0]  din_hold_q, din_hold_d;

  logic        issuing;
  logic        io_stall;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic [1:0]  rd_idx;
  logic [31:0] merged;
  logic [31:0] ext;
  logic        gnt_if, gnt_ls;

  function automatic logic [2:0] op_len(input logic [1:0] sz);
    case (sz)
      2'b00:   op_len = 3'd1;
      2'b01:   op_len = 3'd2;
      default: op_len = 3'd4;
    endcase
  endfunction

  assign issuing  = (state_q != IDLE) && (cnt_q < len_q);
  assign io_stall = (state_q == LS_WR) && (addr_q[17:16] == 2'b11) && io_buffer_full;
  assign wr_byte  = 8'(wdata_q >> {cnt_q[1:0], 3'b000});

  assign mem_a    = issuing ? addr_q + {29'd0, cnt_q} : 32'd0;
  assign mem_dout = (state_q == LS_WR) ? wr_byte : 8'd0;
  assign mem_wr   = (state_q == LS_WR) && rdy_in && !io_stall;

  // A freeze keeps the same address on the bus, so the byte that belongs to the
  // last active address is the one seen in the first frozen cycle.
  assign rdy_prev_d = rdy_in;
  assign din_hold_d = rdy_prev_q ? mem_din : din_hold_q;
  assign rd_byte    = rdy_prev_q ? mem_din : din_hold_q;

  assign rd_idx = cnt_q[1:0] - 2'd1;
  assign merged = buf_q | ({24'd0, rd_byte} << {rd_idx, 3'b000});

  always_comb begin
    ext = merged;
    case (len_q)
      3'd1:    ext = uns_q ? {24'd0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
      3'd2:    ext = uns_q ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    last_d     = last_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    gnt_if     = 1'b0;
    gnt_ls     = 1'b0;

    if (!rdy_in) begin
      if_done_d = if_done_q;
      ls_done_d = ls_done_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (!clear) begin
            gnt_if = if_req && !if_done_q;
            gnt_ls = ls_req && !ls_done_q;
            if (gnt_if && gnt_ls) begin
              gnt_if = last_q;
              gnt_ls = !last_q;
            end
            if (gnt_if) begin
              state_d = IF_RD;
              addr_d  = if_addr;
              len_d   = 3'd4;
              uns_d   = 1'b1;
              cnt_d   = 3'd0;
              buf_d   = 32'd0;
              last_d  = 1'b0;
            end else if (gnt_ls) begin
              state_d = ls_we ? LS_WR : LS_RD;
              addr_d  = ls_addr;
              wdata_d = ls_wdata;
              len_d   = op_len(ls_op[1:0]);
              uns_d   = ls_op[2];
              cnt_d   = 3'd0;
              buf_d   = 32'd0;
              last_d  = 1'b1;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (clear) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            if (cnt_q != 3'd0) buf_d = merged;
            if (cnt_q == len_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == IF_RD) begin
                if_done_d = 1'b1;
                if_data_d = merged;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = ext;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        LS_WR: begin
          // Stores are committed: clear has no effect here.
          if (!io_stall) begin
            if (cnt_q == len_q - 3'd1) begin
              state_d   = IDLE;
              cnt_d     = 3'd0;
              ls_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd4;
      last_q     <= 1'b1;
      uns_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
      rdy_prev_q <= 1'b1;
      din_hold_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      last_q     <= last_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      rdy_prev_q <= rdy_prev_d;
      din_hold_q <= din_hold_d;
    end
  end

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model with its own shadow memory.
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done, ls_req, ls_we, ls_done;
  logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_op;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_op(ls_op), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  bit [7:0] ram    [bit [31:0]];
  bit [7:0] shadow [bit [31:0]];

  // byte RAM with one cycle of read latency
  always @(posedge clk_in) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit rnd_mode = 0, if_drop = 0, ls_drop = 0;

  // model: st 0 idle, 1 fetch, 2 load, 3 store; e = 1-based progress through the access
  int          m_st, m_e, m_n;
  logic [31:0] m_addr, m_wdata, m_ifdata, m_lsdata;
  bit          m_uns, m_last, m_ifd, m_lsd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    shadow[a] = b;
  endtask

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ld_exp(input logic [31:0] a, input int n, input bit uns);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = sh_rd(a + 32'(i));
    if (n == 1 && !uns) v[31:8]  = {24{v[7]}};
    if (n == 2 && !uns) v[31:16] = {16{v[15]}};
    return v;
  endfunction

  function automatic int size_of(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom % 3)
      0:       return 32'h0000_0200 + 32'($urandom % 64);
      1:       return 32'h0003_0000 + 32'($urandom % 16);
      default: return 32'hFFFF_FFFC + 32'($urandom % 4);
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    case ($urandom % 5)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_e = 0; m_n = 4; m_last = 1; m_ifd = 0; m_lsd = 0;
    m_ifdata = 32'd0; m_lsdata = 32'd0; m_addr = 32'd0; m_wdata = 32'd0; m_uns = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk_in);
    cyc++;
    if (if_drop) begin if_req = 0; if_drop = 0; end
    if (ls_drop) begin ls_req = 0; ls_drop = 0; end
    if (rnd_mode) begin
      rst_in = ($urandom % 400) == 0;
      rdy_in = ($urandom % 8) != 0;
      clear  = ($urandom % 16) == 0;
      io_buffer_full = ($urandom % 3) == 0;
      if (!if_req && ($urandom % 3) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end else if (m_st == 1) if_addr = rand_addr();
      if (!ls_req && ($urandom % 3) == 0) begin
        ls_req = 1; ls_we = 1'($urandom % 2); ls_op = rand_op();
        ls_addr = rand_addr(); ls_wdata = $urandom;
      end else if (m_st >= 2) begin
        ls_we = 1'($urandom % 2); ls_op = rand_op(); ls_addr = rand_addr(); ls_wdata = $urandom;
      end
    end
  endtask

  // compare this cycle's outputs, then step the model across the coming edge
  task automatic eval();
    logic [31:0] ea;
    logic [7:0]  edo;
    bit ewr, chka, stall, cur_ifd, cur_lsd, gi, gl;
    #1;
    if (rst_in) model_reset();
    stall = (m_st == 3) && (m_addr[17:16] == 2'b11) && io_buffer_full;
    ea = 32'd0; edo = 8'd0; ewr = 0; chka = 1;
    if (m_st != 0) begin
      if (m_e <= m_n) begin
        ea = m_addr + 32'(m_e - 1);
        if (m_st == 3) begin
          edo = m_wdata[8*(m_e-1) +: 8];
          ewr = rdy_in && !stall;
        end
      end else chka = 0;
    end
    if (chka) begin
      chk("mem_a", mem_a, ea);
      chk("mem_dout", {24'd0, mem_dout}, {24'd0, edo});
    end
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, ewr});
    chk("if_done", {31'd0, if_done}, {31'd0, m_ifd});
    chk("ls_done", {31'd0, ls_done}, {31'd0, m_lsd});
    chk("if_data", if_data, m_ifdata);
    chk("ls_rdata", ls_rdata, m_lsdata);
    if (m_ifd && rdy_in) if_drop = 1;
    if (m_lsd && rdy_in) ls_drop = 1;
    if (ewr) shadow[ea] = edo;
    if (!rst_in && rdy_in) begin
      cur_ifd = m_ifd; cur_lsd = m_lsd;
      m_ifd = 0; m_lsd = 0;
      case (m_st)
        0: if (!clear) begin
          gi = if_req && !cur_ifd;
          gl = ls_req && !cur_lsd;
          if (gi && gl) begin gi = m_last; gl = !m_last; end
          if (gi) begin
            m_st = 1; m_addr = if_addr; m_n = 4; m_uns = 1; m_last = 0; m_e = 1;
          end else if (gl) begin
            m_st = ls_we ? 3 : 2; m_addr = ls_addr; m_n = size_of(ls_op);
            m_uns = ls_op[2]; m_wdata = ls_wdata; m_last = 1; m_e = 1;
          end
        end
        1, 2: if (clear) m_st = 0;
              else if (m_e == m_n + 1) begin
                if (m_st == 1) begin m_ifd = 1; m_ifdata = ld_exp(m_addr, 4, 1); end
                else begin m_lsd = 1; m_lsdata = ld_exp(m_addr, m_n, m_uns); end
                m_st = 0;
              end else m_e++;
        default: if (!stall) begin
                   if (m_e == m_n) begin m_st = 0; m_lsd = 1; end
                   else m_e++;
                 end
      endcase
    end
  endtask

  task automatic wait_done(input bit ch, input int t0, input int lat, input bit chk_d,
                           input logic [31:0] exp_d, input string nm);
    bit seen = 0;
    int k = 0;
    while (!seen && k < 40) begin
      next_cycle(); eval(); k++;
      if (ch ? ls_done : if_done) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within 40 cycles, expected latency %0d", nm, lat);
    end else begin
      chk({nm, " latency"}, 32'(cyc - t0), 32'(lat));
      if (chk_d) chk({nm, " data"}, ch ? ls_rdata : if_data, exp_d);
    end
  endtask

  task automatic start_ls(input bit we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
    ls_req = 1; ls_we = we; ls_op = op; ls_addr = a; ls_wdata = wd;
  endtask

  int t0, cnt_ev;

  initial begin
    rst_in = 1; rdy_in = 1; clear = 0; io_buffer_full = 0;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_op = 0; ls_addr = 0; ls_wdata = 0;
    model_reset();
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h20, 8'h80); poke(32'h42, 8'h5A);

    next_cycle(); eval();
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset if_data", if_data, 32'd0);
    next_cycle(); rst_in = 0; eval();
    next_cycle(); eval();

    // instruction fetch
    next_cycle(); if_req = 1; if_addr = 32'h100; t0 = cyc; eval();
    wait_done(0, t0, 6, 1, 32'h0000_0513, "fetch");

    // lb / lbu
    next_cycle(); start_ls(0, 3'b000, 32'h20, 0); t0 = cyc; eval();
    wait_done(1, t0, 3, 1, 32'hFFFF_FF80, "lb");
    next_cycle(); next_cycle(); start_ls(0, 3'b100, 32'h20, 0); t0 = cyc; eval();
    wait_done(1, t0, 3, 1, 32'h0000_0080, "lbu");

    // sh
    next_cycle(); start_ls(1, 3'b001, 32'h40, 32'h1234_ABCD); t0 = cyc; eval();
    wait_done(1, t0, 3, 0, 0, "sh");
    chk("sh byte0", {24'd0, ram[32'h40]}, 32'hCD);
    chk("sh byte1", {24'd0, ram[32'h41]}, 32'hAB);
    chk("sh byte2 untouched", {24'd0, ram[32'h42]}, 32'h5A);

    // simultaneous requests out of reset, then a second tie
    next_cycle(); rst_in = 1; eval();
    next_cycle(); rst_in = 0; if_req = 1; if_addr = 32'h100;
    start_ls(0, 3'b100, 32'h20, 0); t0 = cyc; eval();
    wait_done(0, t0, 6, 1, 32'h0000_0513, "tie1 fetch");
    wait_done(1, t0, 9, 1, 32'h0000_0080, "tie1 load");
    next_cycle(); if_req = 1; ls_req = 1; t0 = cyc; eval();
    wait_done(0, t0, 6, 1, 32'h0000_0513, "tie2 fetch");
    wait_done(1, t0, 9, 1, 32'h0000_0080, "tie2 load");

    // clear aborts a fetch at byte 2
    next_cycle(); if_req = 1; if_addr = 32'h100; eval();
    next_cycle(); eval(); next_cycle(); eval();
    next_cycle(); clear = 1; eval();
    next_cycle(); clear = 0; if_req = 0; eval();
    chk("clear fetch idle mem_a", mem_a, 32'd0);
    cnt_ev = 0;
    for (int i = 0; i < 8; i++) begin next_cycle(); eval(); if (if_done) cnt_ev++; end
    chk("clear fetch no done", 32'(cnt_ev), 32'd0);

    // clear does not abort a store
    next_cycle(); start_ls(1, 3'b010, 32'h50, 32'hDEAD_BEEF); t0 = cyc; eval();
    next_cycle(); eval();
    next_cycle(); clear = 1; eval();
    next_cycle(); clear = 0; eval();
    wait_done(1, t0, 5, 0, 0, "sw under clear");
    chk("sw word", {ram[32'h53], ram[32'h52], ram[32'h51], ram[32'h50]}, 32'hDEAD_BEEF);

    // UART-full stall on an IO-space byte store
    next_cycle(); start_ls(1, 3'b000, 32'h0003_0000, 32'h77); io_buffer_full = 1; t0 = cyc; eval();
    cnt_ev = 0;
    for (int i = 0; i < 5; i++) begin next_cycle(); eval(); if (mem_wr) cnt_ev++; end
    chk("io stall no write", 32'(cnt_ev), 32'd0);
    next_cycle(); io_buffer_full = 0; eval();
    chk("io write strobe", {31'd0, mem_wr}, 32'd1);
    wait_done(1, t0, 7, 0, 0, "sb io");
    chk("io byte", {24'd0, ram[32'h0003_0000]}, 32'h77);

    // freeze in the middle of a word load
    next_cycle(); start_ls(0, 3'b010, 32'h100, 0); t0 = cyc; eval();
    next_cycle(); eval();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); rdy_in = 0; eval();
      chk("freeze mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    next_cycle(); rdy_in = 1; eval();
    wait_done(1, t0, 9, 1, 32'h0000_0513, "lw with freeze");

    // reset mid-fetch: re-request is served from scratch
    next_cycle(); if_req = 1; if_addr = 32'h100; t0 = cyc; eval();
    next_cycle(); eval();
    next_cycle(); rst_in = 1; eval();
    next_cycle(); rst_in = 0; eval();
    wait_done(0, t0, 9, 1, 32'h0000_0513, "fetch after reset");

    // randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) begin next_cycle(); eval(); end
    rnd_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
